mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_bus_arbiter.sv | 117 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory bus arbiter: FSM states, grant owner and
// the starvation limit that forces a pending fetch through.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

    localparam logic [1:0] STARVE_LIMIT = 2'd3;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates a fetch port and a data port onto one unified memory bus,
// one outstanding transaction at a time, data-first with fetch anti-starvation.
module mem_bus_arbiter
    import mem_arb_pkg::*;
(
    input  logic        clk,
    input  logic        clrn,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        busy
);

    state_t     state;
    state_t     next_state;
    gnt_t       gnt;
    logic [1:0] dcnt;
    logic       pick_fetch;

    // Fetch wins when it is alone or when data has won too many times in a row.
    assign pick_fetch = i_req && (!d_req || (dcnt == STARVE_LIMIT));

    assign m_req   = (state == BUSY);
    assign busy    = (state != IDLE);
    assign i_ready = (state == RESP) && (gnt == GNT_I);
    assign d_ready = (state == RESP) && (gnt == GNT_D);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (m_ack) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Grant capture in IDLE and read-data capture on completion in BUSY.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            gnt     <= GNT_I;
            dcnt    <= 2'd0;
            m_we    <= 1'b0;
            m_addr  <= 32'd0;
            m_wdata <= 32'd0;
            i_rdata <= 32'd0;
            d_rdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_fetch) begin
                        gnt     <= GNT_I;
                        m_addr  <= i_addr;
                        m_we    <= 1'b0;
                        m_wdata <= 32'd0;
                        dcnt    <= 2'd0;
                    end else if (d_req) begin
                        gnt     <= GNT_D;
                        m_addr  <= d_addr;
                        m_we    <= d_we;
                        m_wdata <= d_wdata;
                        if (!i_req) begin
                            dcnt <= 2'd0;
                        end else if (dcnt != STARVE_LIMIT) begin
                            dcnt <= dcnt + 2'd1;
                        end
                    end
                end
                BUSY: begin
                    if (m_ack) begin
                        if (gnt == GNT_I) begin
                            i_rdata <= m_rdata;
                        end else if (!m_we) begin
                            d_rdata <= m_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter; the bench plays the
// memory side by driving m_ack/m_rdata by hand at each step.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        clrn;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter dut (
        .clk     (clk),
        .clrn    (clrn),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ready (i_ready),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_ready (d_ready),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ack   (m_ack),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic ir, input logic [31:0] ia,
                                  input logic dr, input logic dw,
                                  input logic [31:0] da, input logic [31:0] dd);
        i_req   = ir;
        i_addr  = ia;
        d_req   = dr;
        d_we    = dw;
        d_addr  = da;
        d_wdata = dd;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_bit({tag, "_m_req"}, m_req, 1'b0);
        check_bit({tag, "_busy"}, busy, 1'b0);
        check_bit({tag, "_i_ready"}, i_ready, 1'b0);
        check_bit({tag, "_d_ready"}, d_ready, 1'b0);
    endtask

    initial begin
        clrn    = 1'b0;
        m_ack   = 1'b0;
        m_rdata = 32'd0;
        apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        tick();
        check_idle_outputs("reset");
        check_bit("reset_m_we", m_we, 1'b0);
        check_word("reset_m_addr", m_addr, 32'd0);
        check_word("reset_m_wdata", m_wdata, 32'd0);
        check_word("reset_i_rdata", i_rdata, 32'd0);
        check_word("reset_d_rdata", d_rdata, 32'd0);
        clrn = 1'b1;
        tick();
        check_idle_outputs("idle_noreq");

        // Fetch only
        apply_stimulus(1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        check_bit("f_m_req", m_req, 1'b1);
        check_word("f_m_addr", m_addr, 32'h0000_0040);
        check_bit("f_m_we", m_we, 1'b0);
        check_bit("f_busy", busy, 1'b1);
        m_ack   = 1'b1;
        m_rdata = 32'h8C22_0004;
        tick();
        m_ack = 1'b0;
        i_req = 1'b0;
        check_bit("f_i_ready", i_ready, 1'b1);
        check_bit("f_d_ready", d_ready, 1'b0);
        check_bit("f_m_req_resp", m_req, 1'b0);
        check_word("f_i_rdata", i_rdata, 32'h8C22_0004);
        tick();
        check_idle_outputs("f_done");

        // Simultaneous requests: load wins, then fetch
        apply_stimulus(1'b1, 32'h0000_0044, 1'b1, 1'b0, 32'h0000_0100, 32'd0);
        tick();
        check_word("both_first_addr", m_addr, 32'h0000_0100);
        m_ack   = 1'b1;
        m_rdata = 32'hDEAD_BEEF;
        tick();
        m_ack = 1'b0;
        d_req = 1'b0;
        check_bit("both_d_ready", d_ready, 1'b1);
        check_bit("both_i_ready_low", i_ready, 1'b0);
        check_word("both_d_rdata", d_rdata, 32'hDEAD_BEEF);
        check_word("both_i_rdata_kept", i_rdata, 32'h8C22_0004);
        tick();
        check_idle_outputs("both_gap");
        tick();
        check_word("both_second_addr", m_addr, 32'h0000_0044);
        m_ack   = 1'b1;
        m_rdata = 32'h1111_2222;
        tick();
        m_ack = 1'b0;
        i_req = 1'b0;
        check_bit("both_i_ready", i_ready, 1'b1);
        check_bit("both_d_ready_low", d_ready, 1'b0);
        check_word("both_i_rdata", i_rdata, 32'h1111_2222);
        check_word("both_d_rdata_kept", d_rdata, 32'hDEAD_BEEF);
        tick();

        // Store
        apply_stimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678);
        tick();
        for (int c = 0; c < 2; c++) begin
            check_bit("st_m_req", m_req, 1'b1);
            check_bit("st_m_we", m_we, 1'b1);
            check_word("st_m_addr", m_addr, 32'h0000_0200);
            check_word("st_m_wdata", m_wdata, 32'h1234_5678);
            if (c == 0) tick();
        end
        m_ack   = 1'b1;
        m_rdata = 32'hFFFF_FFFF;
        tick();
        m_ack = 1'b0;
        apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        check_bit("st_d_ready", d_ready, 1'b1);
        check_word("st_d_rdata_kept", d_rdata, 32'hDEAD_BEEF);
        tick();

        // Starvation: three loads win, then the waiting fetch, then the last load
        apply_stimulus(1'b1, 32'h0000_0080, 1'b1, 1'b0, 32'h0000_0300, 32'd0);
        for (int n = 0; n < 3; n++) begin
            tick();
            check_word("sv_load_addr", m_addr, 32'h0000_0300 + 32'(n * 4));
            m_ack   = 1'b1;
            m_rdata = 32'hC000_0000 + 32'(n);
            tick();
            m_ack = 1'b0;
            check_bit("sv_load_ready", d_ready, 1'b1);
            check_word("sv_load_rdata", d_rdata, 32'hC000_0000 + 32'(n));
            d_addr = 32'h0000_0300 + 32'((n + 1) * 4);
            tick();
        end
        tick();
        check_word("sv_fetch_addr", m_addr, 32'h0000_0080);
        check_bit("sv_fetch_we", m_we, 1'b0);
        m_ack   = 1'b1;
        m_rdata = 32'hAAAA_0001;
        tick();
        m_ack = 1'b0;
        i_req = 1'b0;
        check_bit("sv_fetch_ready", i_ready, 1'b1);
        check_word("sv_fetch_rdata", i_rdata, 32'hAAAA_0001);
        tick();
        tick();
        check_word("sv_last_addr", m_addr, 32'h0000_030C);
        m_ack   = 1'b1;
        m_rdata = 32'hC000_0003;
        tick();
        m_ack = 1'b0;
        d_req = 1'b0;
        check_bit("sv_last_ready", d_ready, 1'b1);
        check_word("sv_last_rdata", d_rdata, 32'hC000_0003);
        tick();

        // Delayed ack after seven BUSY cycles, requester drops midway
        apply_stimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h0000_0400, 32'd0);
        tick();
        for (int c = 1; c <= 7; c++) begin
            check_bit("dl_m_req", m_req, 1'b1);
            check_word("dl_m_addr", m_addr, 32'h0000_0400);
            check_bit("dl_d_ready_low", d_ready, 1'b0);
            if (c == 3) d_req = 1'b0;
            if (c < 7) tick();
        end
        m_ack   = 1'b1;
        m_rdata = 32'h55AA_55AA;
        tick();
        m_ack = 1'b0;
        check_bit("dl_d_ready", d_ready, 1'b1);
        check_word("dl_d_rdata", d_rdata, 32'h55AA_55AA);
        tick();
        check_idle_outputs("dl_done");

        // Stray ack while idle
        m_ack   = 1'b1;
        m_rdata = 32'h0BAD_0BAD;
        tick();
        m_ack = 1'b0;
        check_idle_outputs("stray_ack");
        check_word("stray_d_rdata", d_rdata, 32'h55AA_55AA);
        check_word("stray_i_rdata", i_rdata, 32'hAAAA_0001);

        // Reset mid-BUSY
        apply_stimulus(1'b1, 32'h0000_0500, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        check_bit("rb_m_req", m_req, 1'b1);
        tick();
        tick();
        clrn = 1'b0;
        #1;
        check_idle_outputs("rb_async");
        check_word("rb_m_addr", m_addr, 32'd0);
        check_word("rb_i_rdata", i_rdata, 32'd0);
        check_word("rb_d_rdata", d_rdata, 32'd0);
        i_req = 1'b0;
        tick();
        clrn = 1'b1;
        m_ack   = 1'b1;
        m_rdata = 32'h7777_7777;
        tick();
        m_ack = 1'b0;
        check_idle_outputs("rb_late_ack");
        check_word("rb_late_i_rdata", i_rdata, 32'd0);
        tick();
        check_bit("rb_no_pulse", i_ready, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
